// File: rtl/morse_decoder.sv
`default_nettype none
// morse_decoder: times key presses, classifies short/long symbols and decodes 5-symbol digit codes to BCD.
// Optional key debounce filter enabled by defining MORSE_DEC_DEBOUNCE_EN.
module morse_decoder #(
    parameter int LONG_TICKS     = 1000000,
    parameter int GAP_TICKS      = 2000000,
    parameter int DEBOUNCE_TICKS = 200000,
    parameter int CNT_W          = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       key_in,
    output logic [3:0] digit,
    output logic       valid,
    output logic       err,
    output logic [2:0] sym_cnt,
    output logic [4:0] morse_code
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LONG_THR = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_TICKS - 1);

    logic key_meta_q;
    logic key_s_q;
    logic key_f;
    logic key_prev_q;
    logic w_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_meta_q <= key_in;
            key_s_q    <= key_meta_q;
            key_prev_q <= key_f;
        end
    end

`ifdef MORSE_DEC_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DB_END = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             key_f_q;
    logic             key_f_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;

    // Any cycle where key_s agrees with key_f restarts the stability count.
    always_comb begin
        key_f_d  = key_f_q;
        db_cnt_d = '0;
        if (key_s_q != key_f_q) begin
            if (db_cnt_q >= DB_END) begin
                key_f_d = key_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_f_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            key_f_q  <= key_f_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign key_f = key_f_q;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_TICKS > 0);
    assign key_f = key_s_q;
`endif

    assign w_rise = key_f & ~key_prev_q;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       sym_cnt_q;
    logic [2:0]       sym_cnt_d;
    logic [4:0]       code_q;
    logic [4:0]       code_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [3:0]       digit_q;
    logic [3:0]       digit_d;
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_sym;
    logic             w_legal;
    logic [3:0]       w_value;

    assign w_cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign w_sym     = (cnt_q >= LONG_THR);

    always_comb begin
        w_legal = 1'b1;
        w_value = 4'd0;
        case (code_q)
            5'b11111: w_value = 4'd0;
            5'b01111: w_value = 4'd1;
            5'b00111: w_value = 4'd2;
            5'b00011: w_value = 4'd3;
            5'b00001: w_value = 4'd4;
            5'b00000: w_value = 4'd5;
            5'b10000: w_value = 4'd6;
            5'b11000: w_value = 4'd7;
            5'b11100: w_value = 4'd8;
            5'b11110: w_value = 4'd9;
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sym_cnt_d = sym_cnt_q;
        code_d    = code_q;
        ovf_d     = ovf_q;
        digit_d   = digit_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (!en) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            sym_cnt_d = 3'd0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (w_rise) begin
                        state_d = S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (key_f) begin
                        cnt_d = w_cnt_inc;
                    end else begin
                        if (sym_cnt_q == 3'd0) begin
                            code_d = {4'b0000, w_sym};
                        end else if (sym_cnt_q < 3'd5) begin
                            code_d = {code_q[3:0], w_sym};
                        end
                        if (sym_cnt_q < 3'd5) begin
                            sym_cnt_d = sym_cnt_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (key_f) begin
                        cnt_d   = '0;
                        state_d = S_PRESS;
                    end else begin
                        cnt_d = w_cnt_inc;
                        // Close is decided on the GAP_TICKS-th low cycle of key_f
                        // (the falling cycle itself was consumed in PRESS).
                        if (w_cnt_inc == GAP_END) begin
                            state_d   = S_IDLE;
                            cnt_d     = '0;
                            sym_cnt_d = 3'd0;
                            ovf_d     = 1'b0;
                            if ((sym_cnt_q == 3'd5) && !ovf_q && w_legal) begin
                                digit_d = w_value;
                                valid_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sym_cnt_q <= 3'd0;
            code_q    <= 5'd0;
            ovf_q     <= 1'b0;
            digit_q   <= 4'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sym_cnt_q <= sym_cnt_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign digit      = digit_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign sym_cnt    = sym_cnt_q;
    assign morse_code = code_q;

endmodule
`default_nettype wire
